// File: rtl/vga_framebuffer.sv
// Pixel framebuffer: AXI-lite style single-beat writes with lane strobes, a
// full-frame clear engine and a 1-cycle scan-out read port. Optional macro
// VGA_FB_BYPASS_EN forwards the pixel being written to a same-cycle read.
module vga_framebuffer #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 17,
    parameter int DEPTH      = 76800,
    parameter int LANE_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            awaddr,
    input  logic [2:0]                       awprot,
    input  logic                             awvalid,
    output logic                             awready,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wstrb,
    input  logic                             wvalid,
    output logic                             wready,
    output logic [1:0]                       bresp,
    output logic                             bvalid,
    input  logic                             bready,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    input  logic                             clr_start,
    input  logic [DATA_WIDTH-1:0]            clr_value,
    output logic                             clr_busy,
    output logic [1:0]                       dbg_state_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / LANE_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP, CLEAR} state_e;

    state_e                  state_q, state_d;
    logic                    aw_cap_q, aw_cap_d;
    logic                    w_cap_q, w_cap_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    clr_pending_q, clr_pending_d;
    logic [DATA_WIDTH-1:0]   clr_value_q, clr_value_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    aw_hs, w_hs, addr_ok, accept_block;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata, lane_mask, merged;
    logic                    rd_hit;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    unused_awprot;

    assign unused_awprot = ^awprot;

    // A pending clear only blocks new traffic once nothing is half-captured,
    // so a transaction that already has one channel in hand can finish.
    assign accept_block = clr_pending_q && !aw_cap_q && !w_cap_q;
    assign aw_hs        = awvalid && awready;
    assign w_hs         = wvalid && wready;
    assign addr_ok      = {1'b0, addr_q} < DEPTH_C;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            lane_mask[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{strb_q[i]}};
        end
    end

    assign merged = (mem[addr_q] & ~lane_mask) | (data_q & lane_mask);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= W_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE: begin
                if ((aw_cap_q || aw_hs) && (w_cap_q || w_hs)) begin
                    state_d = W_COMMIT;
                end else if (accept_block) begin
                    state_d = CLEAR;
                end
            end
            W_COMMIT: state_d = W_RESP;
            W_RESP:   if (bready) state_d = W_IDLE;
            CLEAR:    if (clr_cnt_q == LAST_PIX) state_d = W_IDLE;
            default:  state_d = W_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = merged;
        case (state_q)
            W_IDLE: begin
                awready = rst_n && !aw_cap_q && !accept_block;
                wready  = rst_n && !w_cap_q && !accept_block;
            end
            W_COMMIT: mem_we = addr_ok;
            W_RESP:   bvalid = 1'b1;
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = clr_value_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        aw_cap_d      = aw_cap_q;
        w_cap_d       = w_cap_q;
        addr_d        = addr_q;
        data_d        = data_q;
        strb_d        = strb_q;
        bresp_d       = bresp_q;
        clr_pending_d = clr_pending_q;
        clr_value_d   = clr_value_q;
        clr_cnt_d     = '0;

        if (aw_hs) begin
            aw_cap_d = 1'b1;
            addr_d   = awaddr;
        end
        if (w_hs) begin
            w_cap_d = 1'b1;
            data_d  = wdata;
            strb_d  = wstrb;
        end
        if (state_q == W_COMMIT) begin
            bresp_d = addr_ok ? RESP_OKAY : RESP_SLVERR;
        end
        if (state_q == W_RESP && bready) begin
            aw_cap_d = 1'b0;
            w_cap_d  = 1'b0;
        end

        if (state_q == W_IDLE && state_d == CLEAR) begin
            clr_pending_d = 1'b0;
        end else if (clr_start && !clr_pending_q && state_q != CLEAR) begin
            clr_pending_d = 1'b1;
            clr_value_d   = clr_value;
        end
        if (state_q == CLEAR && clr_cnt_q != LAST_PIX) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rd_hit  = {1'b0, rd_addr} < DEPTH_C;
        rd_word = rd_hit ? mem[rd_addr] : '0;
`ifdef VGA_FB_BYPASS_EN
        if (rd_hit && mem_we && rd_addr == mem_waddr) begin
            rd_word = mem_wdata;
        end
`endif
        rd_data_d  = rd_en ? rd_word : rd_data_q;
        rd_valid_d = rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cap_q      <= 1'b0;
            w_cap_q       <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            strb_q        <= '0;
            bresp_q       <= RESP_OKAY;
            clr_pending_q <= 1'b0;
            clr_value_q   <= '0;
            clr_cnt_q     <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            aw_cap_q      <= aw_cap_d;
            w_cap_q       <= w_cap_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            strb_q        <= strb_d;
            bresp_q       <= bresp_d;
            clr_pending_q <= clr_pending_d;
            clr_value_q   <= clr_value_d;
            clr_cnt_q     <= clr_cnt_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // Pixel storage is deliberately not reset; an aborted clear leaves it partial.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bresp       = bresp_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign clr_busy    = clr_pending_q || state_q == CLEAR;
    assign dbg_state_o = state_q;

endmodule
